// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: four requesters share one APB master through an IDLE/BUSY/DONE handshake.
// Round-robin by default; define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module apb_req_arbiter #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32
) (
  input  logic               Pclk,
  input  logic               Preset,
  input  logic [3:0]         req,
  input  logic [4*ASIZE-1:0] req_addr,
  input  logic [4*DSIZE-1:0] req_wdata,
  input  logic [3:0]         req_write,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic [DSIZE-1:0]   rdata,
  output logic               transfer,
  output logic [ASIZE-1:0]   addr_temp,
  output logic [DSIZE-1:0]   data_temp,
  output logic               write_enable,
  input  logic               Psel,
  input  logic               Penable,
  input  logic               Pready,
  input  logic [DSIZE-1:0]   rdata_temp
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [1:0] pick;
  function automatic logic [1:0] lowest(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
  endfunction
`ifdef APB_ARB_FIXED_PRIO_EN
  assign pick = lowest(req);
`else
  logic [1:0] last_grant, start;
  logic [3:0] rot;
  // rotate so the requester after the last winner sits at bit 0
  assign start = last_grant + 2'd1;
  assign rot   = 4'({req, req} >> start);
  assign pick  = lowest(rot) + start;
`endif
  // drop the request during ENABLE so the master does not issue a second SETUP
  assign transfer = (state == BUSY) && !(Psel && Penable);
  always_ff @(posedge Pclk or posedge Preset)
    if (Preset) begin
      state        <= IDLE;
      gnt          <= '0;
      done         <= '0;
      rdata        <= '0;
      addr_temp    <= '0;
      data_temp    <= '0;
      write_enable <= 1'b0;
`ifndef APB_ARB_FIXED_PRIO_EN
      last_grant   <= 2'd3;
`endif
    end else
      case (state)
        IDLE: if (|req) begin
          state        <= BUSY;
          gnt          <= 4'b0001 << pick;
          addr_temp    <= req_addr[pick*ASIZE +: ASIZE];
          data_temp    <= req_wdata[pick*DSIZE +: DSIZE];
          write_enable <= req_write[pick];
`ifndef APB_ARB_FIXED_PRIO_EN
          last_grant   <= pick;
`endif
        end
        BUSY: if (Psel && Penable && Pready) begin
          state <= DONE;
          done  <= gnt;
          rdata <= write_enable ? '0 : rdata_temp;
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed and randomized checks of apb_req_arbiter against a transaction-level model,
// with a small APB master/slave environment driving Psel/Penable/Pready.
module tb_apb_req_arbiter;
  localparam int AW = 32, DW = 32;
  logic Pclk = 0, Preset = 0;
  logic [3:0] req = 0, req_write = 0;
  logic [4*AW-1:0] req_addr = 0;
  logic [4*DW-1:0] req_wdata = 0;
  logic [3:0] gnt, done;
  logic [DW-1:0] rdata, data_temp, rdata_temp = 0;
  logic [AW-1:0] addr_temp;
  logic transfer, write_enable;
  logic Psel = 0, Penable = 0, Pready = 0;
  int errors = 0, checks = 0;
  int mst = 0, acc_cnt = 0, wait_n = 0, setups = 0;
  int m_phase = 0, m_owner = 0, m_last = 3;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_data = 0, m_rdata = 0;
  logic m_wr = 0;
  int order[$];
  always #5 Pclk = ~Pclk;
  apb_req_arbiter #(.ASIZE(AW), .DSIZE(DW)) dut (
    .Pclk(Pclk), .Preset(Preset), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .gnt(gnt), .done(done), .rdata(rdata), .transfer(transfer),
    .addr_temp(addr_temp), .data_temp(data_temp), .write_enable(write_enable),
    .Psel(Psel), .Penable(Penable), .Pready(Pready), .rdata_temp(rdata_temp)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // transaction-level reference: what the arbiter must do on the coming edge
  task automatic model_step();
    int w;
    w = -1;
    if (m_phase == 0 && req != 0) begin
`ifdef APB_ARB_FIXED_PRIO_EN
      for (int i = 3; i >= 0; i--) if (req[i]) w = i;
`else
      for (int k = 4; k >= 1; k--) if (req[(m_last + k) % 4]) w = (m_last + k) % 4;
      m_last = w;
`endif
      m_owner = w;
      m_addr  = req_addr[w*AW +: AW];
      m_data  = req_wdata[w*DW +: DW];
      m_wr    = req_write[w];
      m_phase = 1;
    end else if (m_phase == 1 && Psel && Penable && Pready) begin
      m_rdata = m_wr ? '0 : rdata_temp;
      m_phase = 2;
    end else if (m_phase == 2) m_phase = 0;
  endtask
  task automatic compare_all();
    logic [3:0] oh;
    oh = (m_phase != 0) ? 4'(1 << m_owner) : 4'd0;
    chk("gnt", gnt, oh);
    chk("done", done, (m_phase == 2) ? oh : 4'd0);
    chk("transfer", transfer, (m_phase == 1) && !(Psel && Penable));
    if (m_phase != 0) begin
      chk("addr_temp", addr_temp, m_addr);
      chk("data_temp", data_temp, m_data);
      chk("write_enable", write_enable, m_wr);
    end
    if (m_phase == 2) chk("rdata", rdata, m_rdata);
  endtask
  task automatic tick();
    int nxt;
    model_step();
    nxt = (mst == 0) ? (transfer ? 1 : 0) : (mst == 1) ? 2 : (Pready ? (transfer ? 1 : 0) : 2);
    @(posedge Pclk);
    #1;
    acc_cnt = (mst == 2 && nxt == 2) ? acc_cnt + 1 : 0;
    if (nxt == 1 && mst != 1) setups++;
    mst = nxt;
    Psel = (mst != 0);
    Penable = (mst == 2);
    Pready = (mst == 2) && (acc_cnt >= wait_n);
    #1;
    compare_all();
    if (done != 0) begin
      order.push_back($clog2(done));
      chk("one_setup", setups, 1);
      setups = 0;
    end
  endtask
  task automatic do_reset();
    Preset = 1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_transfer", transfer, 0);
    chk("rst_addr", addr_temp, 0);
    chk("rst_data", data_temp, 0);
    chk("rst_we", write_enable, 0);
    m_phase = 0; m_last = 3; m_rdata = 0;
    mst = 0; acc_cnt = 0; setups = 0;
    Psel = 0; Penable = 0; Pready = 0;
    @(posedge Pclk);
    #1;
    Preset = 0;
    #1;
    chk("rel_gnt", gnt, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, tx, g, d;
    int last_idx;
    logic [DW-1:0] rd;
    int exp_order[5];
`ifdef APB_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    #1;
    req = 4'b0001;
    do_reset();
    // single zero-wait write from requester 0
    req_addr[0 +: AW] = 32'h10; req_wdata[0 +: DW] = 32'hA5A5A5A5; req_write = 4'b0001; wait_n = 0;
    n = -1; tx = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      tx += int'(transfer);
      if (done != 0) begin n = i; break; end
    end
    req = 0;
    chk("wr_latency", n, 3);
    chk("wr_transfer_cycles", tx, 2);
    chk("wr_we", write_enable, 1);
    chk("wr_done", done, 4'b0001);
    chk("wr_rdata", rdata, 0);
    tick();
    chk("wr_done_pulse", done, 0);
    tick();
    // read from requester 2 with three wait states
    req_addr[2*AW +: AW] = 32'h20; req_write = 4'b0000; rdata_temp = 32'hDEADBEEF; wait_n = 3;
    req = 4'b0100; g = 0; d = 0; rd = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 0) req = 0;
      g += int'(gnt == 4'b0100);
      d += int'(done == 4'b0100);
      if (done == 4'b0100) rd = rdata;
    end
    chk("rd_gnt_cycles", g, 7);
    chk("rd_done_cycles", d, 1);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    // all four requesting continuously
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW] = $urandom; req_wdata[i*DW +: DW] = $urandom;
    end
    req_write = 4'b1010; wait_n = 0; req = 4'hF; order.delete(); last_idx = -1;
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      tick();
      if (done != 0) begin
        if (last_idx >= 0) chk("period", i - last_idx, 5);
        last_idx = i;
      end
    end
    req = 0;
    chk("order_count", order.size(), 5);
    for (int i = 0; i < 5; i++) chk("grant_order", (i < order.size()) ? order[i] : 99, exp_order[i]);
    tick(); tick();
    // reset while BUSY with Pready held low
    wait_n = 1000; req = 4'b0010;
    tick();
    req = 0;
    chk("busy_gnt", gnt, 4'b0010);
    for (int i = 0; i < 4; i++) tick();
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    wait_n = 0; req = 4'b0101;
    tick();
    req = 0;
    chk("post_rst_gnt", gnt, 4'b0001);
    for (int i = 0; i < 6; i++) tick();
    // request dropped during BUSY still completes, no regrant
    req = 4'b1000; n = -1;
    tick();
    req = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done != 0) begin n = i; break; end
    end
    chk("drop_done", done, 4'b1000);
    chk("drop_latency", n, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_regrant", gnt, 0);
    end
    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        for (int i = 0; i < 4; i++) begin
          req_addr[i*AW +: AW] = $urandom; req_wdata[i*DW +: DW] = $urandom;
        end
      req_write = 4'($urandom_range(0, 15));
      rdata_temp = $urandom;
      if (mst == 0) wait_n = $urandom_range(0, 3);
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter ASIZE, default 32, meaning address width.
REQ-002 SHALL have parameter DSIZE, default 32, meaning data width.
REQ-003 SHALL have port Pclk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Preset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  in  4  per-requester transfer request; requester i is bit i.
REQ-006 SHALL have port req_addr  in  4*ASIZE  requester i address at [i*ASIZE +: ASIZE].
REQ-007 SHALL have port req_wdata  in  4*DSIZE  requester i write data at [i*DSIZE +: DSIZE].
REQ-008 SHALL have port req_write  in  4  requester i direction; 1 = write, 0 = read.
REQ-009 SHALL have port gnt  out  4  one-hot grant, held for the whole transaction.
REQ-010 SHALL have port done  out  4  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rdata  out  DSIZE  read data returned with done.
REQ-012 SHALL have port transfer  out  1  transfer request to the APB master.
REQ-013 SHALL have ports addr_temp (ASIZE), data_temp (DSIZE), write_enable (1)  out  registered command to the APB master.
REQ-014 SHALL have ports Psel, Penable, Pready (1 each) and rdata_temp (DSIZE)  in  APB master/slave status and read data.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 In IDLE with req != 0, SHALL pick a winner on the clock edge, go to BUSY, set gnt to the winner's one-hot value, and latch its addr, wdata and write into addr_temp, data_temp and write_enable.
REQ-017 In IDLE with req == 0, SHALL stay in IDLE with gnt = 0.
REQ-018 Arbitration SHALL be round-robin.
  - Search starts at (last_grant+1) mod 4, ascending with wrap.
  - last_grant updates only on a grant.
REQ-019 transfer SHALL be combinational: (state==BUSY) && !(Psel && Penable).
  - It deasserts during ENABLE, so the master returns to IDLE instead of issuing a duplicate SETUP.
REQ-020 In BUSY, completion SHALL be Psel && Penable && Pready on a clock edge.
  - On that edge: go to DONE and capture rdata_temp into rdata for reads; rdata = 0 for writes.
REQ-021 In BUSY without completion (including Pready held low), SHALL remain in BUSY with no cycle limit.
REQ-022 In DONE, done[winner] SHALL be 1 for exactly one cycle, gnt SHALL still be asserted, and the next state SHALL be IDLE.
REQ-023 On leaving DONE, gnt SHALL clear; done SHALL never be nonzero outside DONE.
REQ-024 req SHALL be sampled only in IDLE.
  - Dropping req in BUSY or DONE does not abort.
  - A req still high in IDLE after done starts a new transaction.
REQ-025 Latency SHALL be as follows.
  - req sampled on edge k gives gnt and transfer high after edge k.
  - With zero-wait Pready, completion occurs at edge k+3.
  - done is high during cycle k+3..k+4.
  - Minimum request-to-request period is 5 cycles.
REQ-026 addr_temp, data_temp and write_enable SHALL be stable from grant until DONE exits.

Reset
REQ-027 Asserting Preset at any time, including mid-transaction, SHALL immediately force the following.
  - state = IDLE.
  - gnt = 0, done = 0, rdata = 0.
  - addr_temp = 0, data_temp = 0, write_enable = 0, so transfer = 0.
  - last_grant = 3, so requester 0 has first priority after reset.
REQ-028 The first grant after Preset deasserts SHALL occur no earlier than the first rising edge with Preset low.

Configuration
REQ-029 With macro APB_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: lowest index wins and last_grant is unused.
REQ-030 Without APB_ARB_FIXED_PRIO_EN, SHALL use the round-robin of REQ-018; all other behaviour is identical in both builds.

Verification
REQ-031 The bench SHALL cover these directed scenarios.
  - Single write: req=0001, addr0=0x10, wdata0=0xA5A5A5A5, write=1, Pready=1 -> transfer for 2 cycles, write_enable=1, done=0001 at k+3, rdata=0.
  - Read with 3 wait states: req=0100, addr2=0x20, slave returns 0xDEADBEEF -> gnt=0100 held 7 cycles, done=0100 one cycle, rdata=0xDEADBEEF.
  - All four requesting continuously, round-robin build -> grant order 0,1,2,3,0; each done pulse exactly one cycle; no duplicate APB SETUP.
  - Same as previous with APB_ARB_FIXED_PRIO_EN -> requester 0 granted every transaction.
  - Preset pulsed while in BUSY with Pready=0 -> gnt=0, transfer=0 next sample, no done; next grant goes to requester 0.
  - req dropped during BUSY -> transaction completes, done still pulses, no new grant.
